// File: rtl/muldiv_pkg.sv
// muldiv_pkg: funct3 op codes, FSM states and operand-signedness helpers for muldiv_unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    // MUL only keeps the low half, which is the same for any signedness.
    function automatic logic is_signed_a(input op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(input op_e op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_div(input op_e op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: turns the magnitude product or {remainder, quotient} into the final RV M result.
module muldiv_signfix
    import muldiv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  op_e               op,
    input  logic [2*XLEN-1:0] raw,
    input  logic              neg_a,
    input  logic              neg_b,
    input  logic [XLEN-1:0]   a,
    input  logic              b_zero,
    output logic [XLEN-1:0]   res
);

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;

    // Divide-by-zero is pinned explicitly; the overflow case falls out of the magnitude path.
    always_comb begin
        prod = (neg_a ^ neg_b) ? -raw : raw;
        quot = b_zero ? '1 : (neg_a ^ neg_b) ? -raw[XLEN-1:0] : raw[XLEN-1:0];
        rem  = b_zero ? a : neg_a ? -raw[2*XLEN-1:XLEN] : raw[2*XLEN-1:XLEN];
        res  = is_div(op) ? (op[1] ? rem : quot)
             : (op == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV M multiply/divide, one bit per cycle over XLEN cycles.
// MULDIV_FAST_SPECIAL_EN: divide-by-zero, signed overflow and zero-operand multiply finish in one cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    op_e               op_q, op_d;
    logic              neg_a_q, neg_a_d;
    logic              neg_b_q, neg_b_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   dsr_q, dsr_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   result_q, result_d;

    op_e               op_in;
    logic              sa, sb, accept;
    logic [XLEN-1:0]   mag_a, mag_b, fixed;
    logic [XLEN:0]     mul_sum, rem_sh, rem_sub;
    logic [2*XLEN-1:0] mul_step, div_step;

    assign op_in   = op_e'(op);
    assign sa      = is_signed_a(op_in) & a[XLEN-1];
    assign sb      = is_signed_b(op_in) & b[XLEN-1];
    assign mag_a   = sa ? -a : a;
    assign mag_b   = sb ? -b : b;
    assign accept  = start & (state_q == IDLE || state_q == DONE);

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dsr_q} : '0);
    assign mul_step = {mul_sum, acc_q[XLEN-1:1]};
    assign rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign rem_sub  = rem_sh - {1'b0, dsr_q};
    assign div_step = rem_sub[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                    : {rem_sub[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

`ifdef MULDIV_FAST_SPECIAL_EN
    logic            div_op, b_is_zero, ovf, fast_hit;
    logic [XLEN-1:0] fast_res;
    assign div_op    = is_div(op_in);
    assign b_is_zero = b == '0;
    assign ovf       = div_op & is_signed_b(op_in) & (a == {1'b1, {(XLEN-1){1'b0}}}) & (&b);
    assign fast_hit  = div_op ? (b_is_zero | ovf) : (a == '0 | b_is_zero);
    assign fast_res  = !div_op ? '0 : b_is_zero ? (op_in[1] ? a : '1) : (op_in[1] ? '0 : a);
`endif

    muldiv_signfix #(.XLEN(XLEN)) u_signfix (
        .op     (op_q),
        .raw    (acc_q),
        .neg_a  (neg_a_q),
        .neg_b  (neg_b_q),
        .a      (a_q),
        .b_zero (dsr_q == '0),
        .res    (fixed)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        a_d      = a_q;
        dsr_d    = dsr_q;
        acc_d    = acc_q;
        result_d = result_q;
        if (kill) begin
            state_d = IDLE;
        end else if (accept) begin
            state_d = CALC;
            cnt_d   = CW'(XLEN - 1);
            op_d    = op_in;
            neg_a_d = sa;
            neg_b_d = sb;
            a_d     = a;
            dsr_d   = is_div(op_in) ? mag_b : mag_a;
            acc_d   = {{XLEN{1'b0}}, is_div(op_in) ? mag_a : mag_b};
`ifdef MULDIV_FAST_SPECIAL_EN
            if (fast_hit) begin
                state_d  = DONE;
                result_d = fast_res;
            end
`endif
        end else begin
            case (state_q)
                CALC: begin
                    acc_d   = is_div(op_q) ? div_step : mul_step;
                    cnt_d   = cnt_q - 1'b1;
                    state_d = (cnt_q == '0) ? FIX : CALC;
                end
                FIX: begin
                    result_d = fixed;
                    state_d  = DONE;
                end
                DONE:    state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= OP_MUL;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            a_q      <= '0;
            dsr_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            a_q      <= a_d;
            dsr_q    <= dsr_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign busy   = state_q == CALC || state_q == FIX;
    assign done   = state_q == DONE;
    assign result = result_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative, parametrised-width multiply/divide execution unit for the multicycle RISC-V datapath, implementing the eight RV M-extension operations selected by funct3. The control FSM launches it with a one-cycle `start` pulse, holds in a wait state while `busy` is high, and writes `result` into the register file on `done`. The unit replaces any combinational multiplier on the ALU path, so ALU timing is unaffected by XLEN.

## Interface
- `XLEN`, default 64: operand and result width; legal values are 32 and 64.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: launch request, sampled on the rising edge.
- `kill` input 1: synchronous abort of the current operation.
- `op` input 3: funct3 code. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a` input XLEN: rs1 operand (dividend / multiplicand).
- `b` input XLEN: rs2 operand (divisor / multiplier).
- `busy` output 1: operation in progress.
- `done` output 1: one-cycle pulse; `result` is valid in this cycle.
- `result` output XLEN: last completed result, held until the next completion.

## Operation
- States:
  - IDLE: not busy, waiting for `start`.
  - CALC: XLEN iterations, `busy`=1.
  - FIX: sign correction and high/low select, `busy`=1.
  - DONE: `done`=1, `busy`=0.
- `start` is accepted in IDLE or DONE. On acceptance, `op`, `a` and `b` are latched, the iteration counter is loaded with XLEN-1, and the state goes to CALC.
- `start` while `busy` is high is ignored. Operands are not re-latched.
- Both operations run on magnitudes. Operand signs are recorded at launch according to signedness: MULH and DIV/REM are signed on both operands; MULHSU is signed on `a` only; the U variants are unsigned.
- Multiply: shift-add, one multiplier bit per CALC cycle, into a 2·XLEN accumulator. MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits of the sign-corrected 2·XLEN product.
- Divide: restoring, one quotient bit per CALC cycle. The quotient is negated if the operand signs differ (signed ops). The remainder takes the sign of the dividend.
- Special cases follow the RISC-V spec exactly:
  - Divide by zero: quotient all-ones, remainder = `a`.
  - Signed overflow (most-negative / −1): quotient = `a`, remainder = 0.
- CALC → FIX when the counter reaches 0. FIX → DONE always. DONE → IDLE unless a new `start` is accepted.
- `kill`: the next edge goes to IDLE from any state. No `done` pulse is produced and `result` is unchanged. `kill` together with `start` means `start` is ignored.
- `result` updates only on entry to DONE.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, counter=0, all internal registers 0.
- Reset mid-operation aborts immediately, with no `done` pulse.
- Normal latency, counting the `start` cycle as cycle 0:
  - `busy` is high in cycles 1..XLEN+1.
  - `done` is high in cycle XLEN+2.
  - For XLEN=64, `done` is in cycle 66.
- Back-to-back operation: `start` asserted in the DONE cycle launches the next operation with zero idle cycles.
- No combinational path from any input to `busy`, `done` or `result`.

## Configuration
- `MULDIV_FAST_SPECIAL_EN` defined: divide by zero, signed-division overflow, and multiply with either operand zero skip CALC and FIX. The next state after `start` is DONE, so `done` is high in cycle 1.
- `MULDIV_FAST_SPECIAL_EN` undefined: every operation takes the full XLEN+2 latency. Result values are identical with or without the macro.

## Structure
- Package `muldiv_pkg` holds:
  - the `op` funct3 constants as an enum;
  - the state enum (IDLE, CALC, FIX, DONE);
  - helper functions `is_signed_a(op)`, `is_signed_b(op)`, `is_div(op)`.
- One sub-module, `muldiv_signfix`: combinational. It takes the raw magnitude product or quotient/remainder plus the recorded signs and `op`, and produces the final XLEN-bit result. It is used in the FIX state.

## Test plan
All scenarios use XLEN=64.
- MUL with `a`=7, `b`=−3 → `result`=0xFFFF_FFFF_FFFF_FFEB; `done` only in cycle 66; `busy` high in cycles 1–65.
- MULHU with `a`=`b`=0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFE. MULH with the same operands → 0. MULHSU with `a`=−1, `b`=2 → 0xFFFF_FFFF_FFFF_FFFF.
- DIV −7/2 → 0xFFFF_FFFF_FFFF_FFFD. REM −7/2 → 0xFFFF_FFFF_FFFF_FFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 5/0 → all-ones. REMU 5/0 → 5. DIV 0x8000_0000_0000_0000 / −1 → 0x8000_0000_0000_0000. REM on the same operands → 0.
  - With `MULDIV_FAST_SPECIAL_EN`: `done` in cycle 1.
  - Without it: `done` in cycle 66.
- Assert `kill` in cycle 10 → `busy`=0 from cycle 11, no `done`, `result` keeps its prior value. A second `start` in cycle 3 of an operation is ignored.
- Drive `reset` low in cycle 20 → `busy`, `done` and `result` are 0 immediately. Back-to-back case: `start` in the DONE cycle → second `done` exactly 66 cycles later.
